// File: rtl/pipe_hazard_sb_pkg.sv
// rtl/pipe_hazard_sb_pkg.sv - shared types, encodings and parameter check for the hazard scoreboard
package pipe_hazard_pkg;

  // Scoreboard rd is stored at a fixed maximum width and zero-extended on entry.
  localparam int RD_MAX_W = 8;
  localparam int FWD_RF   = 0;

  typedef struct packed {
    logic                vld;
    logic                wr;
    logic                ld;
    logic [RD_MAX_W-1:0] rd;
  } sb_entry_t;

  function automatic bit params_ok(int reg_aw, int stages, int load_ready, int br_stage);
    return (reg_aw >= 1) && (reg_aw <= RD_MAX_W) && (stages >= 2) &&
           (load_ready >= 2) && (load_ready <= stages) &&
           (br_stage >= 2) && (br_stage <= stages);
  endfunction

endpackage

// File: rtl/pipe_hazard_sb_if.sv
// rtl/pipe_hazard_sb_if.sv - ID-stage request and hazard-control bundle
interface pipe_hazard_sb_if #(
  parameter int REG_AW = 5,
  parameter int STAGES = 3,
  parameter int CNT_W  = 16
);
  localparam int FW = $clog2(STAGES + 1);

  logic              id_valid_i;
  logic [REG_AW-1:0] id_rs_i;
  logic [REG_AW-1:0] id_rt_i;
  logic              id_rs_used_i;
  logic              id_rt_used_i;
  logic [REG_AW-1:0] id_rd_i;
  logic              id_regwrite_i;
  logic              id_memread_i;
  logic              br_taken_i;
  logic              pc_write_o;
  logic              if_id_write_o;
  logic              if_flush_o;
  logic [STAGES-1:0] stage_flush_o;
  logic [FW-1:0]     fwd_a_o;
  logic [FW-1:0]     fwd_b_o;
  logic [CNT_W-1:0]  stall_cnt_o;
  logic [CNT_W-1:0]  flush_cnt_o;

  modport master (
    output id_valid_i, id_rs_i, id_rt_i, id_rs_used_i, id_rt_used_i,
           id_rd_i, id_regwrite_i, id_memread_i, br_taken_i,
    input  pc_write_o, if_id_write_o, if_flush_o, stage_flush_o,
           fwd_a_o, fwd_b_o, stall_cnt_o, flush_cnt_o
  );

  modport slave (
    input  id_valid_i, id_rs_i, id_rt_i, id_rs_used_i, id_rt_used_i,
           id_rd_i, id_regwrite_i, id_memread_i, br_taken_i,
    output pc_write_o, if_id_write_o, if_flush_o, stage_flush_o,
           fwd_a_o, fwd_b_o, stall_cnt_o, flush_cnt_o
  );
endinterface

// File: rtl/pipe_hazard_sb_sat_cnt.sv
// rtl/pipe_hazard_sb_sat_cnt.sv - saturating event counter with enable
module hazard_sat_cnt #(
  parameter int CNT_W = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  output logic [CNT_W-1:0] cnt_o
);
  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != '1)) cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;
endmodule

// File: rtl/pipe_hazard_sb.sv
// rtl/pipe_hazard_sb.sv - shift-register scoreboard driving stall, flush and forwarding selects
module pipe_hazard_sb
  import pipe_hazard_pkg::*;
#(
  parameter int REG_AW     = 5,
  parameter int STAGES     = 3,
  parameter int LOAD_READY = 3,
  parameter int BR_STAGE   = 2,
  parameter int CNT_W      = 16
) (
  input  logic           clk_i,
  input  logic           rst_i,
  pipe_hazard_sb_if.slave hz
);
  localparam int FW = $clog2(STAGES + 1);

  if (!params_ok(REG_AW, STAGES, LOAD_READY, BR_STAGE)) begin : g_bad_params
    $error("pipe_hazard_sb: illegal STAGES/LOAD_READY/BR_STAGE/REG_AW combination");
  end

  function automatic logic [RD_MAX_W-1:0] ext(input logic [REG_AW-1:0] r);
    return RD_MAX_W'(r);
  endfunction

  sb_entry_t         ent_q [1:STAGES];
  sb_entry_t         ent_d [1:STAGES];
  logic [REG_AW-1:0] e1_rs_q, e1_rs_d, e1_rt_q, e1_rt_d;
  logic              e1_rs_used_q, e1_rs_used_d, e1_rt_used_q, e1_rt_used_d;

  logic              br_eff, ld_hit, stall;
  logic              pc_write, if_id_write, if_flush;
  logic [STAGES-1:0] stage_flush;
  logic [FW-1:0]     fwd_a, fwd_b;
  logic              use_a, use_b, hit_a, hit_b, bad_a, bad_b;

  // Only loads younger than LOAD_READY-1 are still waiting for their data.
  always_comb begin
    br_eff = hz.br_taken_i & ent_q[BR_STAGE].vld;
    ld_hit = 1'b0;
    for (int k = 1; k <= LOAD_READY - 2; k++) begin
      if (ent_q[k].vld && ent_q[k].ld && ent_q[k].wr && (ent_q[k].rd != '0) &&
          ((hz.id_rs_used_i && (ent_q[k].rd == ext(hz.id_rs_i))) ||
           (hz.id_rt_used_i && (ent_q[k].rd == ext(hz.id_rt_i)))))
        ld_hit = 1'b1;
    end
    stall = hz.id_valid_i & ld_hit & ~br_eff;
  end

  always_comb begin
    pc_write    = 1'b1;
    if_id_write = 1'b1;
    if_flush    = 1'b0;
    stage_flush = '0;
    if (br_eff) begin
      if_flush = 1'b1;
      for (int k = 1; k <= BR_STAGE; k++) stage_flush[k-1] = 1'b1;
    end else if (stall) begin
      pc_write       = 1'b0;
      if_id_write    = 1'b0;
      stage_flush[0] = 1'b1;
    end
  end

  // Youngest producer wins; a not-yet-ready load blocks older producers too.
  always_comb begin
    fwd_a = FW'(FWD_RF);
    fwd_b = FW'(FWD_RF);
    hit_a = 1'b0;
    hit_b = 1'b0;
    bad_a = 1'b0;
    bad_b = 1'b0;
    use_a = ent_q[1].vld & e1_rs_used_q & (e1_rs_q != '0);
    use_b = ent_q[1].vld & e1_rt_used_q & (e1_rt_q != '0);
    for (int k = 2; k <= STAGES; k++) begin
      if (use_a && !hit_a && ent_q[k].vld && ent_q[k].wr && (ent_q[k].rd == ext(e1_rs_q))) begin
        hit_a = 1'b1;
        if (ent_q[k].ld && (k < LOAD_READY)) bad_a = 1'b1;
        else fwd_a = FW'(k);
      end
      if (use_b && !hit_b && ent_q[k].vld && ent_q[k].wr && (ent_q[k].rd == ext(e1_rt_q))) begin
        hit_b = 1'b1;
        if (ent_q[k].ld && (k < LOAD_READY)) bad_b = 1'b1;
        else fwd_b = FW'(k);
      end
    end
  end

  always_comb begin
    ent_d[1]     = '0;
    e1_rs_d      = '0;
    e1_rt_d      = '0;
    e1_rs_used_d = 1'b0;
    e1_rt_used_d = 1'b0;
    if (hz.id_valid_i && !stage_flush[0]) begin
      ent_d[1]     = '{vld: 1'b1, wr: hz.id_regwrite_i, ld: hz.id_memread_i, rd: ext(hz.id_rd_i)};
      e1_rs_d      = hz.id_rs_i;
      e1_rt_d      = hz.id_rt_i;
      e1_rs_used_d = hz.id_rs_used_i;
      e1_rt_used_d = hz.id_rt_used_i;
    end
    for (int k = 2; k <= STAGES; k++)
      ent_d[k] = stage_flush[k-1] ? '0 : ent_q[k-1];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int k = 1; k <= STAGES; k++) ent_q[k] <= '0;
      e1_rs_q      <= '0;
      e1_rt_q      <= '0;
      e1_rs_used_q <= 1'b0;
      e1_rt_used_q <= 1'b0;
    end else begin
      ent_q        <= ent_d;
      e1_rs_q      <= e1_rs_d;
      e1_rt_q      <= e1_rt_d;
      e1_rs_used_q <= e1_rs_used_d;
      e1_rt_used_q <= e1_rt_used_d;
    end
  end

  always @(posedge clk_i) begin
    if (!rst_i) assert (!(bad_a || bad_b)) else $error("pipe_hazard_sb: forward requested from unready load");
  end

  hazard_sat_cnt #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk_i (clk_i), .rst_i (rst_i), .en_i (stall), .cnt_o (hz.stall_cnt_o)
  );

  hazard_sat_cnt #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk_i (clk_i), .rst_i (rst_i), .en_i (br_eff), .cnt_o (hz.flush_cnt_o)
  );

  assign hz.pc_write_o    = pc_write;
  assign hz.if_id_write_o = if_id_write;
  assign hz.if_flush_o    = if_flush;
  assign hz.stage_flush_o = stage_flush;
  assign hz.fwd_a_o       = fwd_a;
  assign hz.fwd_b_o       = fwd_b;
endmodule

// File: tb/tb_pipe_hazard_sb.sv
// tb/tb_pipe_hazard_sb.sv - directed checks of pipe_hazard_sb at default and deep-pipe settings
module tb_pipe_hazard_sb;
  logic clk = 1'b0;
  logic rst_a, rst_b;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  pipe_hazard_sb_if #(.REG_AW(5), .STAGES(3), .CNT_W(16)) ifa ();
  pipe_hazard_sb_if #(.REG_AW(5), .STAGES(5), .CNT_W(4))  ifb ();

  pipe_hazard_sb #(.REG_AW(5), .STAGES(3), .LOAD_READY(3), .BR_STAGE(2), .CNT_W(16)) dut_a (
    .clk_i (clk), .rst_i (rst_a), .hz (ifa.slave)
  );

  pipe_hazard_sb #(.REG_AW(5), .STAGES(5), .LOAD_READY(4), .BR_STAGE(2), .CNT_W(4)) dut_b (
    .clk_i (clk), .rst_i (rst_b), .hz (ifb.slave)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0d required %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue_a(input int v, input int rs, input int rt, input int rsu, input int rtu,
                         input int rd, input int rw, input int mr);
    ifa.id_valid_i    = v[0];
    ifa.id_rs_i       = rs[4:0];
    ifa.id_rt_i       = rt[4:0];
    ifa.id_rs_used_i  = rsu[0];
    ifa.id_rt_used_i  = rtu[0];
    ifa.id_rd_i       = rd[4:0];
    ifa.id_regwrite_i = rw[0];
    ifa.id_memread_i  = mr[0];
    #1;
  endtask

  task automatic issue_b(input int v, input int rs, input int rt, input int rsu, input int rtu,
                         input int rd, input int rw, input int mr);
    ifb.id_valid_i    = v[0];
    ifb.id_rs_i       = rs[4:0];
    ifb.id_rt_i       = rt[4:0];
    ifb.id_rs_used_i  = rsu[0];
    ifb.id_rt_used_i  = rtu[0];
    ifb.id_rd_i       = rd[4:0];
    ifb.id_regwrite_i = rw[0];
    ifb.id_memread_i  = mr[0];
    #1;
  endtask

  task automatic drain_a();
    issue_a(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (3) tick();
  endtask

  initial begin
    rst_a = 1'b1;
    rst_b = 1'b1;
    ifa.br_taken_i = 1'b0;
    ifb.br_taken_i = 1'b0;
    issue_a(0, 0, 0, 0, 0, 0, 0, 0);
    issue_b(0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("rst_pc_write", ifa.pc_write_o, 1);
    chk("rst_if_id_write", ifa.if_id_write_o, 1);
    chk("rst_stage_flush", ifa.stage_flush_o, 0);
    chk("rst_stall_cnt", ifa.stall_cnt_o, 0);
    tick();
    rst_a = 1'b0;
    rst_b = 1'b0;

    // add r3 ; add r3 ; sub r4,r3,r5 -> youngest producer in entry 2
    issue_a(1, 1, 2, 1, 1, 3, 1, 0); tick();
    issue_a(1, 1, 2, 1, 1, 3, 1, 0); tick();
    issue_a(1, 3, 5, 1, 1, 4, 1, 0);
    chk("alu_dep_no_stall", ifa.pc_write_o, 1);
    tick();
    issue_a(0, 0, 0, 0, 0, 0, 0, 0);
    chk("fwd_a_youngest", ifa.fwd_a_o, 2);
    chk("fwd_b_none", ifa.fwd_b_o, 0);
    drain_a();

    // producer two slots ahead -> entry 3
    issue_a(1, 1, 2, 1, 1, 3, 1, 0); tick();
    issue_a(0, 0, 0, 0, 0, 0, 0, 0); tick();
    issue_a(1, 5, 3, 1, 1, 4, 1, 0); tick();
    issue_a(0, 0, 0, 0, 0, 0, 0, 0);
    chk("fwd_b_entry3", ifa.fwd_b_o, 3);
    chk("fwd_a_rf", ifa.fwd_a_o, 0);
    drain_a();

    // lw r5 ; add r6,r5,r7 -> one bubble then forward from entry 3
    issue_a(1, 1, 0, 1, 0, 5, 1, 1);
    chk("lw_no_stall", ifa.pc_write_o, 1);
    tick();
    issue_a(1, 5, 7, 1, 1, 6, 1, 0);
    chk("lu_pc_write", ifa.pc_write_o, 0);
    chk("lu_if_id_write", ifa.if_id_write_o, 0);
    chk("lu_stage_flush", ifa.stage_flush_o, 3'b001);
    chk("lu_stall_cnt_pre", ifa.stall_cnt_o, 0);
    tick();
    chk("lu_released", ifa.pc_write_o, 1);
    chk("lu_stall_cnt", ifa.stall_cnt_o, 1);
    tick();
    issue_a(0, 0, 0, 0, 0, 0, 0, 0);
    chk("lu_fwd_a", ifa.fwd_a_o, 3);
    drain_a();

    // taken branch in entry 2 overrides a load-use stall
    issue_a(1, 1, 2, 1, 1, 0, 0, 0); tick();
    issue_a(1, 1, 0, 1, 0, 8, 1, 1); tick();
    issue_a(1, 8, 8, 1, 1, 9, 1, 0);
    ifa.br_taken_i = 1'b1;
    #1;
    chk("br_pc_write", ifa.pc_write_o, 1);
    chk("br_if_flush", ifa.if_flush_o, 1);
    chk("br_stage_flush", ifa.stage_flush_o, 3'b011);
    tick();
    ifa.br_taken_i = 1'b0;
    issue_a(0, 0, 0, 0, 0, 0, 0, 0);
    chk("br_flush_cnt", ifa.flush_cnt_o, 1);
    chk("br_stall_cnt_same", ifa.stall_cnt_o, 1);

    // entry 2 is now a bubble -> br_taken ignored
    ifa.br_taken_i = 1'b1;
    #1;
    chk("br_bubble_if_flush", ifa.if_flush_o, 0);
    chk("br_bubble_stage_flush", ifa.stage_flush_o, 0);
    tick();
    ifa.br_taken_i = 1'b0;
    #1;
    chk("br_bubble_flush_cnt", ifa.flush_cnt_o, 1);
    drain_a();

    // lw r0 ; reader of r0 -> neither stall nor forward
    issue_a(1, 1, 0, 1, 0, 0, 1, 1); tick();
    issue_a(1, 0, 0, 1, 1, 7, 1, 0);
    chk("r0_no_stall", ifa.pc_write_o, 1);
    tick();
    issue_a(0, 0, 0, 0, 0, 0, 0, 0);
    chk("r0_fwd_a", ifa.fwd_a_o, 0);
    chk("r0_fwd_b", ifa.fwd_b_o, 0);
    drain_a();

    // asynchronous reset in the middle of a load-use stall
    issue_a(1, 1, 0, 1, 0, 5, 1, 1); tick();
    issue_a(1, 5, 7, 1, 1, 6, 1, 0);
    chk("mid_pre_stall", ifa.pc_write_o, 0);
    rst_a = 1'b1;
    #1;
    chk("mid_rst_pc_write", ifa.pc_write_o, 1);
    chk("mid_rst_if_id_write", ifa.if_id_write_o, 1);
    chk("mid_rst_stage_flush", ifa.stage_flush_o, 0);
    chk("mid_rst_stall_cnt", ifa.stall_cnt_o, 0);
    chk("mid_rst_flush_cnt", ifa.flush_cnt_o, 0);
    tick();
    rst_a = 1'b0;
    #1;
    tick();
    issue_a(0, 0, 0, 0, 0, 0, 0, 0);
    chk("post_rst_fwd_a", ifa.fwd_a_o, 0);
    chk("post_rst_stall_cnt", ifa.stall_cnt_o, 0);

    // deep pipe: LOAD_READY=4 gives two bubbles, then forward from entry 4
    issue_b(1, 1, 0, 1, 0, 5, 1, 1);
    chk("b_lw_no_stall", ifb.pc_write_o, 1);
    tick();
    issue_b(1, 5, 7, 1, 1, 6, 1, 0);
    chk("b_stall1", ifb.pc_write_o, 0);
    chk("b_stage_flush", ifb.stage_flush_o, 5'b00001);
    tick();
    chk("b_stall2", ifb.pc_write_o, 0);
    chk("b_stall_cnt1", ifb.stall_cnt_o, 1);
    tick();
    chk("b_released", ifb.pc_write_o, 1);
    chk("b_stall_cnt2", ifb.stall_cnt_o, 2);
    tick();
    issue_b(0, 0, 0, 0, 0, 0, 0, 0);
    chk("b_fwd_a", ifb.fwd_a_o, 4);

    // 20 more stall cycles saturate the 4-bit counter at 15
    for (int i = 0; i < 10; i++) begin
      issue_b(1, 1, 0, 1, 0, 10, 1, 1); tick();
      issue_b(1, 10, 10, 1, 1, 11, 1, 0);
      repeat (3) tick();
    end
    issue_b(0, 0, 0, 0, 0, 0, 0, 0);
    chk("b_stall_cnt_sat", ifb.stall_cnt_o, 15);
    chk("b_flush_cnt", ifb.flush_cnt_o, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
